sh7034_ibus_master: RTL and testbench
=====================================

// Module: sh7034_ibus_master
// PURPOSE
//  Initiator side of the SH7034 internal peripheral bus (IBUS). Accepts one CPU-side access
//  (address, size, R/W, data) at a time and converts it into an IBUS request to on-chip
//  register responders (UBC, timers, DMA, ...). Generates big-endian byte lanes, replicates
//  write data, and extracts read data. Misaligned, unmapped and timed-out accesses report an error.
// PARAMETERS
//  TIMEOUT  15  max CE_R edges with IBUS_BUSY=1 before abort with error; 0 = wait forever
// PORTS
//  CLK        in   1   system clock
//  RST_N      in   1   asynchronous reset, active-low
//  CE_R       in   1   rising-phase clock enable (request launch / write strobe / sample)
//  CE_F       in   1   falling-phase clock enable (responder read phase; passed through, unused here)
//  RES_N      in   1   synchronous soft reset, active-low
//  CPU_A      in   28  access address
//  CPU_DI     in   32  write data, right-justified (byte in [7:0], word in [15:0])
//  CPU_SZ     in   2   0=byte 1=word 2=long 3=reserved (treated as long)
//  CPU_WE     in   1   1=write 0=read
//  CPU_REQ    in   1   access request, level, held until CPU_ACK
//  CPU_DO     out  32  read data, right-justified, zero-extended
//  CPU_ACK    out  1   access complete, high for exactly one CE_R period
//  CPU_ERR    out  1   error qualifier, valid while CPU_ACK=1
//  IBUS_A     out  28  address to responders
//  IBUS_DO    out  32  write data to responders (lane-replicated)
//  IBUS_DI    in   32  read data from responders (OR of all responders)
//  IBUS_BA    out  4   byte-lane enables, [3]=bits 31:24
//  IBUS_WE    out  1   write strobe qualifier
//  IBUS_REQ   out  1   bus request
//  IBUS_BUSY  in   1   responder wait
//  IBUS_ACT   in   1   some responder decodes IBUS_A
// BEHAVIOUR
//  Reset (RST_N=0 async, or RES_N=0 at any CLK edge): state IDLE; all outputs 0; counter 0.
//   Access in flight is aborted, no CPU_ACK issued.
//  All state changes occur only on CLK edges with CE_R=1 (except reset).
//  Lanes: byte BA=4'b1000>>A[1:0]; word BA=A[1]?4'b0011:4'b1100; long BA=4'b1111.
//  Write data: byte {4{DI[7:0]}}, word {2{DI[15:0]}}, long DI.
//  Read extract: byte IBUS_DI lane selected by A[1:0] (A=0 -> [31:24]); word A[1]=0 -> [31:16]
//   else [15:0]; long all 32 bits; result zero-extended into CPU_DO.
//  FSM IDLE / ACCESS / DONE:
//   IDLE: CE_R & CPU_REQ -> misaligned (word A[0]=1, long A[1:0]!=0): no bus cycle, go DONE with
//    CPU_ACK=1, CPU_ERR=1, CPU_DO=0. Else latch A/SZ/WE/data, drive IBUS_A/BA/WE/DO,
//    IBUS_REQ=1, counter=0, go ACCESS.
//   ACCESS (outputs held stable): at each CE_R:
//    IBUS_BUSY=1 and (TIMEOUT=0 or cnt<TIMEOUT): cnt++, stay.
//    IBUS_BUSY=1 and cnt==TIMEOUT!=0: complete, ERR=1, CPU_DO=0.
//    IBUS_BUSY=0: complete, ERR=!IBUS_ACT; read & ACT -> CPU_DO=extract(IBUS_DI); else CPU_DO=0.
//    Complete: IBUS_REQ/WE/BA/DO/A -> 0, CPU_ACK=1, go DONE.
//   DONE: at next CE_R CPU_ACK=0, CPU_ERR=0, go IDLE; CPU_REQ ignored at this edge.
//  Latency (no wait): accept at CE_R n, IBUS_REQ high n..n+1, write strobed / read sampled at
//   n+1, CPU_ACK high n+1..n+2, next accept earliest at n+3.
//  CPU_DO holds last read value until next completion. CPU_ERR never high without CPU_ACK.
//  CPU_A/CPU_DI changes while in ACCESS have no effect (latched at accept).
// TESTING
//  1 Long write 0x12345678 @0x5FFFF90, responder BUSY=0 ACT=1 -> IBUS_BA=1111, IBUS_DO=0x12345678,
//    IBUS_REQ high exactly 1 CE_R period, CPU_ACK at n+1, CPU_ERR=0.
//  2 Byte read @0x5FFFF91, responder IBUS_DI=0xAABBCCDD -> IBUS_BA=0100, CPU_DO=0x000000BB.
//  3 Word write 0xBEEF @0x5FFFF9A -> IBUS_BA=0011, IBUS_DO=0xBEEFBEEF; word read same addr with
//    IBUS_DI=0x1234BEEF -> CPU_DO=0x0000BEEF.
//  4 Long access @0x5FFFF92 -> IBUS_REQ never asserts, CPU_ACK=1 CPU_ERR=1 at CE_R after accept.
//  5 TIMEOUT=15, BUSY held 20 CE_R -> CPU_ACK+ERR at 16th CE_R after accept; BUSY released at
//    3rd -> ACK at 3rd, ERR=0. Read with ACT=0 -> ERR=1, CPU_DO=0.
//  6 RES_N=0 while ACCESS -> next edge all outputs 0, no CPU_ACK; new request after RES_N=1 completes normally.

Source files
------------

// File: rtl/sh7034_ibus_master_if.sv
// CPU-side access port and IBUS initiator port of the SH7034 peripheral-bus master.
// Handshakes: CPU_REQ is a level held until CPU_ACK (one CE_R period, CPU_ERR qualifies it);
// IBUS_REQ and its A/BA/WE/DO stay stable until the responder drops IBUS_BUSY or the access times out.
interface sh7034_ibus_master_if;
  logic [27:0] CPU_A;
  logic [31:0] CPU_DI;
  logic [1:0]  CPU_SZ;
  logic        CPU_WE;
  logic        CPU_REQ;
  logic [31:0] CPU_DO;
  logic        CPU_ACK;
  logic        CPU_ERR;
  logic [27:0] IBUS_A;
  logic [31:0] IBUS_DO;
  logic [31:0] IBUS_DI;
  logic [3:0]  IBUS_BA;
  logic        IBUS_WE;
  logic        IBUS_REQ;
  logic        IBUS_BUSY;
  logic        IBUS_ACT;

  modport master (
    input  CPU_A, CPU_DI, CPU_SZ, CPU_WE, CPU_REQ, IBUS_DI, IBUS_BUSY, IBUS_ACT,
    output CPU_DO, CPU_ACK, CPU_ERR, IBUS_A, IBUS_DO, IBUS_BA, IBUS_WE, IBUS_REQ
  );

  modport slave (
    output CPU_A, CPU_DI, CPU_SZ, CPU_WE, CPU_REQ, IBUS_DI, IBUS_BUSY, IBUS_ACT,
    input  CPU_DO, CPU_ACK, CPU_ERR, IBUS_A, IBUS_DO, IBUS_BA, IBUS_WE, IBUS_REQ
  );
endinterface

// File: rtl/sh7034_ibus_master.sv
// SH7034 IBUS initiator: turns one CPU access into a big-endian IBUS cycle with
// lane generation, write replication, read extraction, misalign/unmapped/timeout errors.
module sh7034_ibus_master #(
  parameter int TIMEOUT = 15
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic                        CE_R,
  input  logic                        CE_F,
  input  logic                        RES_N,
  sh7034_ibus_master_if.master        bus,
  output logic [1:0]                  dbg_state_o,
  output logic                        dbg_ce_f_o
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_V = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      sz_q, sz_d;
  logic [27:0]     ibus_a_q, ibus_a_d;
  logic [31:0]     ibus_do_q, ibus_do_d;
  logic [3:0]      ibus_ba_q, ibus_ba_d;
  logic            ibus_we_q, ibus_we_d;
  logic            ibus_req_q, ibus_req_d;
  logic [31:0]     cpu_do_q, cpu_do_d;
  logic            cpu_ack_q, cpu_ack_d;
  logic            cpu_err_q, cpu_err_d;
  logic            complete;

  // Big-endian lanes: address 0 within a long is bits 31:24.
  function automatic logic [3:0] lanes(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'd0:    return 4'b1000 >> a;
      2'd1:    return a[1] ? 4'b0011 : 4'b1100;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] wdata(input logic [1:0] sz, input logic [31:0] di);
    case (sz)
      2'd0:    return {4{di[7:0]}};
      2'd1:    return {2{di[15:0]}};
      default: return di;
    endcase
  endfunction

  function automatic logic [31:0] extract(input logic [1:0] sz, input logic [1:0] a,
                                          input logic [31:0] d);
    case (sz)
      2'd0: begin
        case (a)
          2'd0:    return {24'h0, d[31:24]};
          2'd1:    return {24'h0, d[23:16]};
          2'd2:    return {24'h0, d[15:8]};
          default: return {24'h0, d[7:0]};
        endcase
      end
      2'd1:    return a[1] ? {16'h0, d[15:0]} : {16'h0, d[31:16]};
      default: return d;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] a);
    return ((sz == 2'd1) && a[0]) || (sz[1] && (a != 2'd0));
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sz_d       = sz_q;
    ibus_a_d   = ibus_a_q;
    ibus_do_d  = ibus_do_q;
    ibus_ba_d  = ibus_ba_q;
    ibus_we_d  = ibus_we_q;
    ibus_req_d = ibus_req_q;
    cpu_do_d   = cpu_do_q;
    cpu_ack_d  = cpu_ack_q;
    cpu_err_d  = cpu_err_q;
    complete   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (CE_R && bus.CPU_REQ) begin
          if (misaligned(bus.CPU_SZ, bus.CPU_A[1:0])) begin
            cpu_ack_d = 1'b1;
            cpu_err_d = 1'b1;
            cpu_do_d  = 32'h0;
            state_d   = S_DONE;
          end else begin
            sz_d       = bus.CPU_SZ;
            ibus_a_d   = bus.CPU_A;
            ibus_we_d  = bus.CPU_WE;
            ibus_ba_d  = lanes(bus.CPU_SZ, bus.CPU_A[1:0]);
            ibus_do_d  = wdata(bus.CPU_SZ, bus.CPU_DI);
            ibus_req_d = 1'b1;
            cnt_d      = '0;
            state_d    = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        if (CE_R) begin
          if (bus.IBUS_BUSY) begin
            // TIMEOUT of zero disables the abort; the counter then stays parked.
            if (TIMEOUT == 0 || cnt_q < TO_V) begin
              if (TIMEOUT != 0) cnt_d = cnt_q + 1'b1;
            end else begin
              complete  = 1'b1;
              cpu_err_d = 1'b1;
              cpu_do_d  = 32'h0;
            end
          end else begin
            complete  = 1'b1;
            cpu_err_d = !bus.IBUS_ACT;
            cpu_do_d  = (!ibus_we_q && bus.IBUS_ACT)
                        ? extract(sz_q, ibus_a_q[1:0], bus.IBUS_DI) : 32'h0;
          end
          if (complete) begin
            ibus_req_d = 1'b0;
            ibus_we_d  = 1'b0;
            ibus_ba_d  = 4'h0;
            ibus_do_d  = 32'h0;
            ibus_a_d   = 28'h0;
            cpu_ack_d  = 1'b1;
            state_d    = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (CE_R) begin
          cpu_ack_d = 1'b0;
          cpu_err_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Soft reset acts on every CLK edge, independent of CE_R, and drops any access in flight.
    if (!RES_N) begin
      state_d    = S_IDLE;
      cnt_d      = '0;
      sz_d       = 2'd0;
      ibus_a_d   = 28'h0;
      ibus_do_d  = 32'h0;
      ibus_ba_d  = 4'h0;
      ibus_we_d  = 1'b0;
      ibus_req_d = 1'b0;
      cpu_do_d   = 32'h0;
      cpu_ack_d  = 1'b0;
      cpu_err_d  = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      sz_q       <= 2'd0;
      ibus_a_q   <= 28'h0;
      ibus_do_q  <= 32'h0;
      ibus_ba_q  <= 4'h0;
      ibus_we_q  <= 1'b0;
      ibus_req_q <= 1'b0;
      cpu_do_q   <= 32'h0;
      cpu_ack_q  <= 1'b0;
      cpu_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sz_q       <= sz_d;
      ibus_a_q   <= ibus_a_d;
      ibus_do_q  <= ibus_do_d;
      ibus_ba_q  <= ibus_ba_d;
      ibus_we_q  <= ibus_we_d;
      ibus_req_q <= ibus_req_d;
      cpu_do_q   <= cpu_do_d;
      cpu_ack_q  <= cpu_ack_d;
      cpu_err_q  <= cpu_err_d;
    end
  end

  assign bus.IBUS_A   = ibus_a_q;
  assign bus.IBUS_DO  = ibus_do_q;
  assign bus.IBUS_BA  = ibus_ba_q;
  assign bus.IBUS_WE  = ibus_we_q;
  assign bus.IBUS_REQ = ibus_req_q;
  assign bus.CPU_DO   = cpu_do_q;
  assign bus.CPU_ACK  = cpu_ack_q;
  assign bus.CPU_ERR  = cpu_err_q;

  assign dbg_state_o  = state_q;
  // Falling-phase enable belongs to the responders; forwarded only for observation.
  assign dbg_ce_f_o   = CE_F;

endmodule

// File: tb/tb_sh7034_ibus_master.sv
// Directed bench for sh7034_ibus_master: driver pushes expected CPU and IBUS
// responses into queues, two monitors pop and compare when the DUT presents them.
module tb_sh7034_ibus_master;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       CE_R = 1'b0;
  logic       CE_F;
  logic       RES_N = 1'b1;
  logic [1:0] dbg_state;
  logic       dbg_ce_f;

  sh7034_ibus_master_if bus();

  sh7034_ibus_master #(.TIMEOUT(15)) dut (
    .CLK(CLK), .RST_N(RST_N), .CE_R(CE_R), .CE_F(CE_F), .RES_N(RES_N),
    .bus(bus), .dbg_state_o(dbg_state), .dbg_ce_f_o(dbg_ce_f)
  );

  // ---------------- clock / reset block ----------------
  always #5 CLK = ~CLK;
  initial forever begin
    @(negedge CLK);
    CE_R = ~CE_R;
  end
  assign CE_F = ~CE_R;

  int ce_cnt = 0;
  always @(posedge CLK) if (CE_R) ce_cnt <= ce_cnt + 1;

  // ---------------- responder model ----------------
  logic [31:0] rsp_di = 32'h0;
  logic        rsp_act = 1'b0;
  int          busy_n = 0;
  int          accept_idx = 0;
  assign bus.IBUS_DI   = bus.IBUS_REQ ? rsp_di : 32'h0;
  assign bus.IBUS_ACT  = bus.IBUS_REQ & rsp_act;
  assign bus.IBUS_BUSY = bus.IBUS_REQ && ((ce_cnt - accept_idx) < busy_n);

  // ---------------- scoreboard ----------------
  int compared = 0;
  int mismatched = 0;
  logic [48:0] cpu_q[$];   // {cpu_do, cpu_err, latency}
  logic [80:0] bus_q[$];   // {a, ba, we, do, req_len}; req_len 16'hFFFF = not checked

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s: event did not occur as required (t=%0t)", name, $time);
  endtask

  // CPU-side monitor
  logic        ack_prev = 1'b0;
  logic [31:0] do_at_ack = 32'h0;
  logic [48:0] ce;
  initial forever begin
    @(posedge CLK); #1;
    check("err_qualified", 64'(bus.CPU_ERR & ~bus.CPU_ACK), 64'(0));
    check("ce_f_fwd", 64'(dbg_ce_f), 64'(CE_F));
    if (bus.CPU_ACK && !ack_prev) begin
      if (cpu_q.size() == 0) begin
        fail("unexpected_cpu_ack");
      end else begin
        ce = cpu_q.pop_front();
        check("cpu_do", 64'(bus.CPU_DO), 64'(ce[48:17]));
        check("cpu_err", 64'(bus.CPU_ERR), 64'(ce[16]));
        check("ack_latency", 64'(16'(ce_cnt - accept_idx)), 64'(ce[15:0]));
      end
      do_at_ack = bus.CPU_DO;
    end
    if (!bus.CPU_ACK && ack_prev) check("cpu_do_hold", 64'(bus.CPU_DO), 64'(do_at_ack));
    ack_prev = bus.CPU_ACK;
  end

  // IBUS-side monitor
  logic        req_prev = 1'b0;
  logic        stable = 1'b1;
  logic [64:0] held = '0;
  logic [80:0] be;
  logic [15:0] exp_len = 16'h0;
  int          rise_ce = 0;
  initial forever begin
    @(posedge CLK); #1;
    if (bus.IBUS_REQ && !req_prev) begin
      if (bus_q.size() == 0) begin
        fail("unexpected_ibus_req");
        exp_len = 16'hFFFF;
      end else begin
        be = bus_q.pop_front();
        check("ibus_a", 64'(bus.IBUS_A), 64'(be[80:53]));
        check("ibus_ba", 64'(bus.IBUS_BA), 64'(be[52:49]));
        check("ibus_we", 64'(bus.IBUS_WE), 64'(be[48]));
        check("ibus_do", 64'(bus.IBUS_DO), 64'(be[47:16]));
        exp_len = be[15:0];
      end
      held    = {bus.IBUS_A, bus.IBUS_BA, bus.IBUS_WE, bus.IBUS_DO};
      stable  = 1'b1;
      rise_ce = ce_cnt;
    end else if (bus.IBUS_REQ) begin
      if ({bus.IBUS_A, bus.IBUS_BA, bus.IBUS_WE, bus.IBUS_DO} !== held) stable = 1'b0;
    end else if (req_prev) begin
      check("ibus_stable", 64'(stable), 64'(1));
      if (exp_len != 16'hFFFF) check("ibus_req_len", 64'(16'(ce_cnt - rise_ce)), 64'(exp_len));
      check("ibus_idle", 64'({bus.IBUS_A, bus.IBUS_BA, bus.IBUS_WE, bus.IBUS_DO}), 64'(0));
    end
    req_prev = bus.IBUS_REQ;
  end

  // ---------------- driver ----------------
  typedef struct {
    logic [1:0]  sz;
    logic        we;
    logic [27:0] a;
    logic [31:0] di;
    logic [31:0] bdi;
    logic        act;
    int          busy;
    logic        launch;
    logic [3:0]  ba;
    logic [31:0] bdo;
    logic [31:0] cdo;
    logic        cerr;
    int          lat;
    logic        hold;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic [1:0] sz, input logic we, input logic [27:0] a,
                         input logic [31:0] di, input logic [31:0] bdi, input logic act,
                         input int busy, input logic launch, input logic [3:0] ba,
                         input logic [31:0] bdo, input logic [31:0] cdo, input logic cerr,
                         input int lat, input logic hold);
    vec_t v;
    v.sz = sz; v.we = we; v.a = a; v.di = di; v.bdi = bdi; v.act = act; v.busy = busy;
    v.launch = launch; v.ba = ba; v.bdo = bdo; v.cdo = cdo; v.cerr = cerr; v.lat = lat;
    v.hold = hold;
    vecs.push_back(v);
  endtask

  task automatic soft_reset_pulse();
    @(negedge CLK); #1;
    if (CE_R) begin
      @(negedge CLK); #1;
    end
    RES_N = 1'b0;
    @(posedge CLK); #1;
    RES_N = 1'b1;
  endtask

  task automatic issue(input vec_t v);
    @(posedge CLK); #1;
    bus.CPU_A  = v.a;
    bus.CPU_DI = v.di;
    bus.CPU_SZ = v.sz;
    bus.CPU_WE = v.we;
    rsp_di     = v.bdi;
    rsp_act    = v.act;
    busy_n     = v.busy;
    accept_idx = ce_cnt + 1;
    bus.CPU_REQ = 1'b1;
  endtask

  task automatic run_vec(input vec_t v);
    logic seen;
    cpu_q.push_back({v.cdo, v.cerr, 16'(v.lat)});
    if (v.launch) bus_q.push_back({v.a, v.ba, v.we, v.bdo, 16'(v.lat)});
    issue(v);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge CLK); #1;
      if (i == 2 && v.busy > 0) begin
        bus.CPU_A  = v.a ^ 28'h000000E;
        bus.CPU_DI = ~v.di;
      end
      if (bus.CPU_ACK) seen = 1'b1;
    end
    if (!seen) begin
      fail("ack_timeout");
      bus.CPU_REQ = 1'b0;
      soft_reset_pulse();
      cpu_q.delete();
      bus_q.delete();
    end
    if (!v.hold) bus.CPU_REQ = 1'b0;
    for (int i = 0; i < 20 && bus.CPU_ACK; i++) begin
      @(posedge CLK); #1;
    end
    bus.CPU_REQ = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    vec_t v;
    bus.CPU_A = 28'h0; bus.CPU_DI = 32'h0; bus.CPU_SZ = 2'd0; bus.CPU_WE = 1'b0;
    bus.CPU_REQ = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK); #1;
    check("reset_cpu", 64'({bus.CPU_DO, bus.CPU_ACK, bus.CPU_ERR}), 64'(0));
    check("reset_ibus", 64'({bus.IBUS_A, bus.IBUS_BA, bus.IBUS_WE, bus.IBUS_REQ}), 64'(0));
    check("reset_ibus_do", 64'(bus.IBUS_DO), 64'(0));
    check("reset_state", 64'(dbg_state), 64'(0));

    //       sz    we    a             di            bdi           act busy launch ba     bdo           cdo           err  lat hold
    add_vec(2'd2, 1'b1, 28'h5FFFF90, 32'h12345678, 32'h0,        1'b1, 0, 1'b1, 4'b1111, 32'h12345678, 32'h0,        1'b0, 1, 1'b0);
    add_vec(2'd0, 1'b0, 28'h5FFFF91, 32'h0,        32'hAABBCCDD, 1'b1, 0, 1'b1, 4'b0100, 32'h0,        32'h000000BB, 1'b0, 1, 1'b0);
    add_vec(2'd1, 1'b1, 28'h5FFFF9A, 32'hDEADBEEF, 32'h0,        1'b1, 0, 1'b1, 4'b0011, 32'hBEEFBEEF, 32'h0,        1'b0, 1, 1'b0);
    add_vec(2'd1, 1'b0, 28'h5FFFF9A, 32'h0,        32'h1234BEEF, 1'b1, 0, 1'b1, 4'b0011, 32'h0,        32'h0000BEEF, 1'b0, 1, 1'b0);
    add_vec(2'd1, 1'b0, 28'h5FFFF98, 32'h0,        32'h1234BEEF, 1'b1, 0, 1'b1, 4'b1100, 32'h0,        32'h00001234, 1'b0, 1, 1'b0);
    add_vec(2'd0, 1'b1, 28'h5FFFF92, 32'h000000A5, 32'h0,        1'b1, 0, 1'b1, 4'b0010, 32'hA5A5A5A5, 32'h0,        1'b0, 1, 1'b0);
    add_vec(2'd0, 1'b0, 28'h5FFFF93, 32'h0,        32'hAABBCCDD, 1'b1, 0, 1'b1, 4'b0001, 32'h0,        32'h000000DD, 1'b0, 1, 1'b1);
    add_vec(2'd2, 1'b0, 28'h5FFFF94, 32'h0,        32'hCAFEF00D, 1'b1, 0, 1'b1, 4'b1111, 32'h0,        32'hCAFEF00D, 1'b0, 1, 1'b0);
    add_vec(2'd2, 1'b0, 28'h5FFFF92, 32'h0,        32'h0,        1'b1, 0, 1'b0, 4'b0000, 32'h0,        32'h0,        1'b1, 0, 1'b0);
    add_vec(2'd0, 1'b0, 28'h5FFFF90, 32'h0,        32'h11223344, 1'b1, 0, 1'b1, 4'b1000, 32'h0,        32'h00000011, 1'b0, 1, 1'b0);
    add_vec(2'd1, 1'b1, 28'h5FFFF91, 32'h00001234, 32'h0,        1'b1, 0, 1'b0, 4'b0000, 32'h0,        32'h0,        1'b1, 0, 1'b0);
    add_vec(2'd3, 1'b0, 28'h5FFFF96, 32'h0,        32'h0,        1'b1, 0, 1'b0, 4'b0000, 32'h0,        32'h0,        1'b1, 0, 1'b0);
    add_vec(2'd1, 1'b0, 28'h5FFFF9E, 32'h0,        32'h11223344, 1'b1, 2, 1'b1, 4'b0011, 32'h0,        32'h00003344, 1'b0, 3, 1'b0);
    add_vec(2'd2, 1'b0, 28'h5FFFF98, 32'h0,        32'h55667788, 1'b1, 20, 1'b1, 4'b1111, 32'h0,       32'h0,        1'b1, 16, 1'b0);
    add_vec(2'd2, 1'b0, 28'h5FFFFA0, 32'h0,        32'hFFFFFFFF, 1'b0, 0, 1'b1, 4'b1111, 32'h0,        32'h0,        1'b1, 1, 1'b0);
    add_vec(2'd0, 1'b1, 28'h5FFFFA1, 32'h0000003C, 32'h0,        1'b0, 0, 1'b1, 4'b0100, 32'h3C3C3C3C, 32'h0,        1'b1, 1, 1'b0);
    add_vec(2'd3, 1'b0, 28'h5FFFF84, 32'h0,        32'h0BADF00D, 1'b1, 0, 1'b1, 4'b1111, 32'h0,        32'h0BADF00D, 1'b0, 1, 1'b0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Soft reset in the middle of a long-waiting access: no ACK, everything cleared.
    v.sz = 2'd2; v.we = 1'b0; v.a = 28'h5FFFF90; v.di = 32'h0; v.bdi = 32'h0; v.act = 1'b1;
    v.busy = 30; v.launch = 1'b1; v.ba = 4'b1111; v.bdo = 32'h0; v.cdo = 32'h0;
    v.cerr = 1'b0; v.lat = 0; v.hold = 1'b0;
    bus_q.push_back({v.a, v.ba, v.we, v.bdo, 16'hFFFF});
    issue(v);
    repeat (6) @(posedge CLK);
    #1;
    check("abort_in_access", 64'(dbg_state), 64'(1));
    bus.CPU_REQ = 1'b0;
    @(negedge CLK); #1;
    if (CE_R) begin
      @(negedge CLK); #1;
    end
    RES_N = 1'b0;
    @(posedge CLK); #1;
    check("res_n_cpu", 64'({bus.CPU_DO, bus.CPU_ACK, bus.CPU_ERR}), 64'(0));
    check("res_n_ibus", 64'({bus.IBUS_A, bus.IBUS_BA, bus.IBUS_WE, bus.IBUS_REQ}), 64'(0));
    check("res_n_state", 64'(dbg_state), 64'(0));
    RES_N = 1'b1;
    busy_n = 0;
    repeat (6) @(posedge CLK);

    v.sz = 2'd1; v.a = 28'h5FFFF9E; v.bdi = 32'h1234ABCD; v.busy = 0; v.ba = 4'b0011;
    v.cdo = 32'h0000ABCD; v.lat = 1;
    run_vec(v);

    repeat (10) @(posedge CLK);
    #1;
    check("cpu_q_drained", 64'(cpu_q.size()), 64'(0));
    check("bus_q_drained", 64'(bus_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
